// File: rtl/rr_packet_allocator.sv
`default_nettype none
// =============================================================================
// rr_packet_allocator - round-robin output-port allocator, tail release, watchdog
// Revision: 1.0
// =============================================================================
module rr_packet_allocator #(
  parameter int PORTS    = 4,
  parameter int ADR_W    = $clog2(PORTS),
  parameter int MAX_HOLD = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADR_W-1:0]            r_adr,
  input  logic [PORTS-1:0][ADR_W+1:0] in_ch_hdr,
  input  logic [PORTS-1:0]            in_vld,
  input  logic                        out_rdy,
  output logic [PORTS-1:0]            in_rdy,
  output logic [PORTS-1:0]            sel,
  output logic                        shift,
  output logic                        busy,
  output logic [$clog2(PORTS)-1:0]    owner,
  output logic                        err
);

  localparam int PTR_W  = $clog2(PORTS);
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [1:0] T_HEADER = 2'b11;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_NULL   = 2'b00;
  localparam logic [PORTS-1:0] ONE = PORTS'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [PORTS-1:0]  req;
  logic              any_req;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  winner_inc;
  logic [1:0]        own_type;
  logic              own_bad;
  logic              tail_xfer;
  logic              wd_fire;
  int                idx;

  for (genvar i = 0; i < PORTS; i++) begin : g_req
    assign req[i] = in_vld[i] && (in_ch_hdr[i][ADR_W+1:ADR_W] == T_HEADER)
                    && (in_ch_hdr[i][ADR_W-1:0] == r_adr);
  end

  // Scan from the far end back to rr_ptr so the closest requester is written last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (req[PTR_W'(idx)]) begin
        winner  = PTR_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign winner_inc = (winner == PTR_W'(PORTS - 1)) ? '0 : winner + 1'b1;
  assign own_type   = in_ch_hdr[owner][ADR_W+1:ADR_W];
  assign own_bad    = in_vld[owner] && ((own_type == T_HEADER) || (own_type == T_NULL));
  assign tail_xfer  = in_vld[owner] && (own_type == T_TAIL) && out_rdy;
  assign wd_fire    = (MAX_HOLD > 0) && (hold_cnt == HOLD_LIM) && !tail_xfer;
  assign busy       = (state == BUSY);

  // Grant is combinational so a header can move in the cycle it is first seen.
  always_comb begin
    sel    = '0;
    in_rdy = '0;
    shift  = 1'b0;
    if (rst_n) begin
      if (state == IDLE) begin
        if (any_req) sel = ONE << winner;
        if (out_rdy) in_rdy = sel;
        shift = any_req && out_rdy;
      end else begin
        sel = ONE << owner;
        if (out_rdy && !own_bad) in_rdy = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && out_rdy) begin
            state    <= BUSY;
            owner    <= winner;
            rr_ptr   <= winner_inc;
            hold_cnt <= '0;
          end
        end
        BUSY: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
          if (tail_xfer) begin
            state <= IDLE;
          end else if (own_bad || wd_fire) begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_packet_allocator.sv
`default_nettype none
// Bench for rr_packet_allocator: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_rr_packet_allocator;

  localparam int P  = 4;
  localparam int AW = 2;
  localparam int MH = 8;
  localparam logic [1:0] HDR = 2'b11, PAY = 2'b10, TL = 2'b01, NUL = 2'b00;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [AW-1:0]            r_adr = '0;
  logic [P-1:0][AW+1:0]     in_ch_hdr = '0;
  logic [P-1:0]             in_vld = '0;
  logic                     out_rdy = 1'b0;
  logic [P-1:0]             in_rdy, sel;
  logic                     shift, busy, err;
  logic [1:0]               owner;

  rr_packet_allocator #(.PORTS(P), .ADR_W(AW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .r_adr(r_adr), .in_ch_hdr(in_ch_hdr),
    .in_vld(in_vld), .out_rdy(out_rdy), .in_rdy(in_rdy), .sel(sel),
    .shift(shift), .busy(busy), .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ownership, rotating pointer, hold age and sticky error.
  bit        m_busy = 0, m_err = 0;
  int        m_owner = 0, m_ptr = 0, m_cnt = 0;
  bit [P-1:0] m_acc = '0;

  always @(negedge clk) begin : p_model
    int  e_sel, e_rdy, e_shift, e_busy, e_owner, e_err, w, j, t;
    bit  found, bad, tailx;
    e_sel = 0; e_rdy = 0; e_shift = 0;
    m_acc = '0;
    if (!rst_n) begin
      m_busy = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      e_busy = 0; e_owner = 0; e_err = 0;
    end else begin
      e_busy = m_busy; e_owner = m_owner; e_err = m_err;
      if (!m_busy) begin
        found = 0; w = 0;
        for (int k = 0; k < P; k++) begin
          j = (m_ptr + k) % P;
          if (!found && in_vld[j] && in_ch_hdr[j][3:2] == HDR && in_ch_hdr[j][1:0] == r_adr) begin
            found = 1; w = j;
          end
        end
        if (found) begin
          e_sel = 1 << w;
          if (out_rdy) begin
            e_rdy = e_sel; e_shift = 1;
            m_busy = 1; m_owner = w; m_ptr = (w + 1) % P; m_cnt = 0;
          end
        end
      end else begin
        e_sel = 1 << m_owner;
        t     = int'(in_ch_hdr[m_owner][3:2]);
        bad   = in_vld[m_owner] && (t == 3 || t == 0);
        tailx = in_vld[m_owner] && t == 1 && out_rdy;
        if (out_rdy && !bad) e_rdy = e_sel;
        if (tailx) m_busy = 0;
        else if (bad || m_cnt == MH - 1) begin
          m_busy = 0; m_err = 1;
        end
        m_cnt++;
      end
    end
    m_acc = P'(e_rdy) & in_vld;
    chk("m_sel",    32'(sel),    32'(e_sel));
    chk("m_in_rdy", 32'(in_rdy), 32'(e_rdy));
    chk("m_shift",  32'(shift),  32'(e_shift));
    chk("m_busy",   32'(busy),   32'(e_busy));
    chk("m_owner",  32'(owner),  32'(e_owner));
    chk("m_err",    32'(err),    32'(e_err));
  end

  // Per-channel packet generators, advanced on model-predicted acceptance.
  int g_pos[P], g_len[P], g_dst[P];
  bit g_rnd = 0;

  task automatic new_pkt(input int i);
    g_pos[i] = 0;
    if (g_rnd) begin
      g_len[i] = $urandom_range(0, 10);
      g_dst[i] = ($urandom_range(0, 9) < 6) ? int'(r_adr) : $urandom_range(0, 3);
    end else begin
      g_len[i] = 0;
      g_dst[i] = int'(r_adr);
    end
  endtask

  task automatic drive_gen();
    logic [1:0] t;
    for (int i = 0; i < P; i++) begin
      if (m_acc[i]) begin
        if (g_pos[i] > g_len[i]) new_pkt(i); else g_pos[i]++;
      end else if (g_rnd && g_pos[i] == 0 && g_dst[i] != int'(r_adr) && $urandom_range(0, 7) == 0)
        g_dst[i] = int'(r_adr);
      else if (g_rnd && g_pos[i] > 0 && $urandom_range(0, 49) == 0)
        new_pkt(i);
      t = (g_pos[i] == 0) ? HDR : (g_pos[i] > g_len[i]) ? TL : PAY;
      if (g_rnd && $urandom_range(0, 99) < 2) t = ($urandom_range(0, 1) == 1) ? HDR : NUL;
      in_ch_hdr[i] = {t, 2'(g_dst[i])};
      in_vld[i]    = g_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    out_rdy = g_rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_ch(input int i, input logic [1:0] t, input logic [1:0] d);
    in_ch_hdr[i] = {t, d};
    in_vld[i]    = 1'b1;
  endtask

  task automatic do_reset(input logic [1:0] adr);
    rst_n = 1'b0; in_vld = '0; out_rdy = 1'b0; r_adr = adr;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  int order[$];
  int exp_ord[5] = '{0, 1, 2, 3, 0};
  int nb;

  initial begin
    // Single packet on ch1 to output 2
    do_reset(2'd2);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0); chk("reset_sel", 32'(sel), 0); chk("reset_err", 32'(err), 0);
    tick();
    set_ch(1, HDR, 2'd2); out_rdy = 1'b1;
    @(negedge clk); chk("t1_sel", 32'(sel), 32'b0010); chk("t1_shift", 32'(shift), 1);
    tick(); set_ch(1, PAY, 2'd2);
    @(negedge clk); chk("t1_busy", 32'(busy), 1); chk("t1_owner", 32'(owner), 1); chk("t1_sel_p", 32'(sel), 32'b0010);
    chk("t1_shift_p", 32'(shift), 0);
    tick(); set_ch(1, PAY, 2'd2);
    @(negedge clk); chk("t1_sel_p2", 32'(sel), 32'b0010);
    tick(); set_ch(1, TL, 2'd2);
    @(negedge clk); chk("t1_sel_t", 32'(sel), 32'b0010); chk("t1_rdy_t", 32'(in_rdy), 32'b0010);
    tick(); in_vld = '0;
    @(negedge clk); chk("t1_release", 32'(busy), 0);
    tick();

    // Four channels of back-to-back header/tail pairs
    do_reset(2'd0);
    g_rnd = 0;
    for (int i = 0; i < P; i++) new_pkt(i);
    for (int c = 0; c < 10; c++) begin
      drive_gen();
      @(negedge clk);
      if (shift === 1'b1)
        for (int i = 0; i < P; i++) if (sel[i]) order.push_back(i);
      tick();
    end
    chk("t2_grants", 32'(order.size()), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) chk("t2_order", 32'(order[k]), 32'(exp_ord[k]));

    // Backpressure while ch2 owns
    do_reset(2'd1);
    set_ch(2, HDR, 2'd1); out_rdy = 1'b1;
    @(negedge clk); chk("t3_grant", 32'(sel), 32'b0100);
    tick(); set_ch(2, PAY, 2'd1); out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_stall_rdy", 32'(in_rdy), 0); chk("t3_stall_sel", 32'(sel), 32'b0100); chk("t3_stall_busy", 32'(busy), 1);
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk); chk("t3_resume", 32'(in_rdy), 32'b0100);
    tick(); set_ch(2, TL, 2'd1);
    @(negedge clk); chk("t3_tail", 32'(in_rdy), 32'b0100);
    tick(); in_vld = '0;
    @(negedge clk); chk("t3_idle", 32'(busy), 0); chk("t3_err", 32'(err), 0);
    tick();

    // Watchdog: ch0 never sends a tail, ch3 waits
    do_reset(2'd1);
    set_ch(0, HDR, 2'd1); set_ch(3, HDR, 2'd1); out_rdy = 1'b1;
    @(negedge clk); chk("t4_first", 32'(sel), 32'b0001);
    tick(); set_ch(0, PAY, 2'd1);
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      nb++;
      tick();
    end
    chk("t4_hold_cycles", 32'(nb), 8);
    chk("t4_err", 32'(err), 1); chk("t4_sel3", 32'(sel), 32'b1000); chk("t4_shift3", 32'(shift), 1);
    tick(); in_vld[3] = 1'b0;
    @(negedge clk); chk("t4_owner3", 32'(owner), 3); chk("t4_busy3", 32'(busy), 1);
    tick();

    // Second header from the owner mid-packet
    do_reset(2'd0);
    set_ch(1, HDR, 2'd0); out_rdy = 1'b1;
    @(negedge clk);
    tick(); set_ch(1, PAY, 2'd0);
    @(negedge clk);
    tick(); set_ch(1, HDR, 2'd0);
    @(negedge clk); chk("t5_rdy_block", 32'(in_rdy), 0); chk("t5_err_pre", 32'(err), 0);
    tick();
    @(negedge clk); chk("t5_idle", 32'(busy), 0); chk("t5_err", 32'(err), 1);
    chk("t5_regrant", 32'(sel), 32'b0010); chk("t5_shift", 32'(shift), 1);
    tick(); in_vld = '0;
    @(negedge clk); chk("t5_owner", 32'(owner), 1);
    tick();

    // Foreign destination never selected; async reset mid-packet
    do_reset(2'd1);
    set_ch(0, HDR, 2'd3); out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk("t6_sel", 32'(sel), 0); chk("t6_shift", 32'(shift), 0);
      tick();
    end
    set_ch(2, HDR, 2'd1);
    @(negedge clk); chk("t6_grant2", 32'(sel), 32'b0100);
    tick(); set_ch(2, NUL, 2'd1);
    @(negedge clk); chk("t6_null_rdy", 32'(in_rdy), 0);
    tick(); set_ch(2, HDR, 2'd1);
    @(negedge clk); chk("t6_regrant", 32'(shift), 1);
    tick(); set_ch(2, PAY, 2'd1);
    @(negedge clk); chk("t6_busy", 32'(busy), 1); chk("t6_err", 32'(err), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_busy", 32'(busy), 0); chk("t6_async_sel", 32'(sel), 0); chk("t6_async_err", 32'(err), 0);
    tick(); in_vld = '0;
    tick(); rst_n = 1'b1;

    // Randomized traffic with occasional resets
    do_reset(2'($urandom_range(0, 3)));
    g_rnd = 1;
    for (int i = 0; i < P; i++) new_pkt(i);
    for (int c = 0; c < 4000; c++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
        for (int i = 0; i < P; i++) new_pkt(i);
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        r_adr = 2'($urandom_range(0, 3));
      end
      drive_gen();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
`default_nettype wire
